dmem_vec_responder: RTL and testbench

Data-memory responder on the memory side of the single-cycle core's data port. It serves scalar loads and stores, and accepts the core's 5-word vector store (`VecWrite` with `VecWriteData_0..4`). A vector store is posted into an internal buffer and drained into a single-write-port RAM at one word per cycle. While the buffer drains, the block asserts `Stall` so the core holds its PC and suppresses side effects.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_ram.sv | 24 ++
 rtl/dmem_vec_responder.sv | 132 +++++++++++++
 tb/tb_dmem_vec_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing constants for the data-memory vector-store responder.
package dmem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int unsigned VEC_WORDS   = 5;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous write, asynchronous read, no reset on contents.
module dmem_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/dmem_vec_responder.sv
// Data-memory responder: scalar loads/stores plus a 5-word vector store drained one word per cycle.
// Optional stall-cycle counter enabled by defining DMEM_STALL_COUNT_EN.
module dmem_vec_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic                   VecWrite,
    input  logic [31:0]            ALUResult,
    input  logic [31:0]            WriteData,
    input  logic [31:0]            VecWriteData_0,
    input  logic [31:0]            VecWriteData_1,
    input  logic [31:0]            VecWriteData_2,
    input  logic [31:0]            VecWriteData_3,
    input  logic [31:0]            VecWriteData_4,
    output logic [31:0]            ReadData,
    output logic                   Stall,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_buf [VEC_WORDS-1];

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_index;
    logic [1:0]        w_buf_sel;
    logic              w_last;
    logic              w_unused;

    assign w_index   = ALUResult[ADDR_W+1:2];
    assign w_unused  = ^{ALUResult[31:ADDR_W+2], ALUResult[1:0]};
    // Buffer holds words 1..4 only; word 0 goes straight to RAM on the accepting edge.
    assign w_buf_sel = 2'(r_idx - IDX_W'(1));
    assign w_last    = (r_idx == IDX_W'(VEC_WORDS - 1));
    assign Stall     = (r_state == DRAIN);

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_waddr      = w_index;
        w_wdata      = WriteData;
        case (r_state)
            IDLE: begin
                if (VecWrite) begin
                    w_we         = 1'b1;
                    w_wdata      = VecWriteData_0;
                    w_next_state = DRAIN;
                end else if (MemWrite) begin
                    w_we = 1'b1;
                end
            end
            DRAIN: begin
                w_we    = 1'b1;
                w_waddr = r_base + ADDR_W'(r_idx);
                w_wdata = r_buf[w_buf_sel];
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_base <= '0;
            for (int unsigned i = 0; i < VEC_WORDS - 1; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (r_state == IDLE) begin
                if (VecWrite) begin
                    r_base   <= w_index;
                    r_buf[0] <= VecWriteData_1;
                    r_buf[1] <= VecWriteData_2;
                    r_buf[2] <= VecWriteData_3;
                    r_buf[3] <= VecWriteData_4;
                    r_idx    <= IDX_W'(1);
                end
            end else begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

`ifdef DMEM_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (Stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign StallCnt = r_stall_cnt;
`else
    assign StallCnt = '0;
`endif

    dmem_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (w_we),
        .waddr(w_waddr),
        .wdata(w_wdata),
        .raddr(w_index),
        .rdata(ReadData)
    );

endmodule

// File: tb/tb_dmem_vec_responder.sv
// Directed bench for dmem_vec_responder with a shadow-memory scoreboard for reads.
module tb_dmem_vec_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, VecWrite;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] VecWriteData_0, VecWriteData_1, VecWriteData_2, VecWriteData_3, VecWriteData_4;
    logic [31:0] ReadData;
    logic        Stall;
    logic [15:0] StallCnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];
    int          exp_cnt  = 0;

    always #5 clk = ~clk;

    dmem_vec_responder #(
        .DEPTH (64),
        .ADDR_W(6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MemWrite      (MemWrite),
        .VecWrite      (VecWrite),
        .ALUResult     (ALUResult),
        .WriteData     (WriteData),
        .VecWriteData_0(VecWriteData_0),
        .VecWriteData_1(VecWriteData_1),
        .VecWriteData_2(VecWriteData_2),
        .VecWriteData_3(VecWriteData_3),
        .VecWriteData_4(VecWriteData_4),
        .ReadData      (ReadData),
        .Stall         (Stall),
        .StallCnt      (StallCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr);
        logic [5:0] idx;
        idx       = addr[7:2];
        ALUResult = addr;
        exp_q.push_back(model[idx]);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            chk(tag, ReadData, exp_q.pop_front());
        end
    endtask

    task automatic scalar_store(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        ALUResult = addr;
        WriteData = data;
        model[addr[7:2]] = data;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic drive_vec(input logic [31:0] addr, input logic [31:0] base_word);
        VecWrite       = 1'b1;
        ALUResult      = addr;
        VecWriteData_0 = base_word;
        VecWriteData_1 = base_word + 32'd1;
        VecWriteData_2 = base_word + 32'd2;
        VecWriteData_3 = base_word + 32'd3;
        VecWriteData_4 = base_word + 32'd4;
    endtask

    task automatic model_vec(input logic [31:0] addr, input logic [31:0] base_word, input int nwords);
        logic [5:0] idx;
        idx = addr[7:2];
        for (int i = 0; i < nwords; i++) begin
            model[idx] = base_word + 32'(i);
            idx        = idx + 6'd1;
        end
    endtask

    // Counts remaining stall cycles, bounded so a stuck Stall cannot hang the run.
    task automatic count_stall(output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!Stall) break;
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] exp_cnt_v;

        reset = 1'b0; MemWrite = 1'b0; VecWrite = 1'b0;
        ALUResult = '0; WriteData = '0;
        VecWriteData_0 = '0; VecWriteData_1 = '0; VecWriteData_2 = '0;
        VecWriteData_3 = '0; VecWriteData_4 = '0;
        #1;
        chk("reset_stall", 32'(Stall), 32'd0);
        chk("reset_stallcnt", 32'(StallCnt), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Scalar store and read-after-write
        MemWrite = 1'b1; ALUResult = 32'h10; WriteData = 32'hDEADBEEF;
        model[4] = 32'hDEADBEEF;
        #1;
        chk("scalar_stall_pre", 32'(Stall), 32'd0);
        tick();
        MemWrite = 1'b0;
        chk("scalar_stall_post", 32'(Stall), 32'd0);
        read_chk("scalar_raw", 32'h10);

        scalar_store(32'h0C, 32'h33333333);
        scalar_store(32'h80, 32'h32323232);

        // Vector store at 0x20 with words 0x11..0x55
        VecWrite = 1'b1; ALUResult = 32'h20;
        VecWriteData_0 = 32'h11; VecWriteData_1 = 32'h22; VecWriteData_2 = 32'h33;
        VecWriteData_3 = 32'h44; VecWriteData_4 = 32'h55;
        model[8] = 32'h11; model[9] = 32'h22; model[10] = 32'h33;
        model[11] = 32'h44; model[12] = 32'h55;
        tick();
        VecWrite = 1'b0;
        read_chk("vec_word0_early", 32'h20);
        count_stall(n);
        chk("vec_stall_len", 32'(n), 32'd4);
        read_chk("vec_w0", 32'h20);
        read_chk("vec_w1", 32'h24);
        read_chk("vec_w2", 32'h28);
        read_chk("vec_w3", 32'h2C);
        read_chk("vec_w4", 32'h30);

        // Back-to-back: wrap-around vector store issued in the first Stall=0 cycle
        drive_vec(32'hF8, 32'hA0);
        model_vec(32'hF8, 32'hA0, 5);
        tick();
        VecWrite = 1'b0;
        count_stall(n);
        chk("wrap_stall_len", 32'(n), 32'd4);
        read_chk("wrap_i62", 32'hF8);
        read_chk("wrap_i63", 32'hFC);
        read_chk("wrap_i0", 32'h00);
        read_chk("wrap_i1", 32'h04);
        read_chk("wrap_i2", 32'h08);
        read_chk("wrap_i3_kept", 32'h0C);
        exp_cnt += 8;
`ifdef DMEM_STALL_COUNT_EN
        exp_cnt_v = 32'(exp_cnt);
`else
        exp_cnt_v = 32'd0;
`endif
        chk("stallcnt_after_two", 32'(StallCnt), exp_cnt_v);

        // Simultaneous strobes, then strobes held during drain
        drive_vec(32'h40, 32'h1);
        MemWrite  = 1'b1;
        WriteData = 32'hAAAA;
        model_vec(32'h40, 32'h1, 5);
        tick();
        VecWrite = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!Stall) break;
            n++;
            MemWrite = 1'b1; VecWrite = 1'b1;
            ALUResult = 32'h80; WriteData = 32'hBEEF;
            tick();
        end
        MemWrite = 1'b0; VecWrite = 1'b0;
        chk("drain_strobe_stall_len", 32'(n), 32'd4);
        read_chk("both_i16", 32'h40);
        read_chk("both_i17", 32'h44);
        read_chk("both_i20", 32'h50);
        read_chk("drain_i32_kept", 32'h80);

        // Reset in the second DRAIN cycle
        for (int i = 0; i < 5; i++) scalar_store(32'hA0 + 32'(4 * i), 32'h5000 + 32'(i));
        drive_vec(32'hA0, 32'hC0);
        model_vec(32'hA0, 32'hC0, 2);
        tick();
        VecWrite = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        chk("rst_mid_stallcnt", 32'(StallCnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_post_stall", 32'(Stall), 32'd0);
        read_chk("rst_w0", 32'hA0);
        read_chk("rst_w1", 32'hA4);
        read_chk("rst_w2_lost", 32'hA8);
        read_chk("rst_w3_lost", 32'hAC);
        read_chk("rst_w4_lost", 32'hB0);

        drive_vec(32'hC0, 32'h700);
        model_vec(32'hC0, 32'h700, 5);
        tick();
        VecWrite = 1'b0;
        count_stall(n);
        chk("fresh_stall_len", 32'(n), 32'd4);
`ifdef DMEM_STALL_COUNT_EN
        exp_cnt_v = 32'd4;
`else
        exp_cnt_v = 32'd0;
`endif
        chk("fresh_stallcnt", 32'(StallCnt), exp_cnt_v);
        read_chk("fresh_w0", 32'hC0);
        read_chk("fresh_w4", 32'hD0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
